// File: rtl/cond_unit_pkg.sv
// cond_unit_pkg: condition codes and NZCV bit positions shared by the
// condition unit and any other block that evaluates ARM-style conditions.
package cond_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_check.sv
// cond_check: combinational evaluation of a 4-bit condition field against NZCV.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign w_n  = Flags[FLAG_N];
    assign w_z  = Flags[FLAG_Z];
    assign w_c  = Flags[FLAG_C];
    assign w_v  = Flags[FLAG_V];
    assign w_ge = (w_n == w_v);

    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            COND_EQ: CondEx = w_z;
            COND_NE: CondEx = ~w_z;
            COND_CS: CondEx = w_c;
            COND_CC: CondEx = ~w_c;
            COND_MI: CondEx = w_n;
            COND_PL: CondEx = ~w_n;
            COND_VS: CondEx = w_v;
            COND_VC: CondEx = ~w_v;
            COND_HI: CondEx = w_c & ~w_z;
            COND_LS: CondEx = ~w_c | w_z;
            COND_GE: CondEx = w_ge;
            COND_LT: CondEx = ~w_ge;
            COND_GT: CondEx = ~w_z & w_ge;
            COND_LE: CondEx = w_z | ~w_ge;
            default: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: execute-stage NZCV register, condition gating of writes and
// executed/skipped instruction counters.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Valid,
    input  logic             Stall,
    input  logic             Flush,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             CFlag,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_exec_cnt, r_skip_cnt;
    logic             w_cond_ex, w_live, w_retire;

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (r_flags),
        .CondEx (w_cond_ex)
    );

    assign w_live   = Valid & ~Flush;
    assign w_retire = w_live & ~Stall;

    assign CondEx    = w_cond_ex;
    assign PCSrc     = PCS & w_cond_ex & w_live;
    assign RegWrite  = RegW & ~NoWrite & w_cond_ex & w_live;
    assign MemWrite  = MemW & w_cond_ex & w_live;
    assign Flags     = r_flags;
    assign CFlag     = r_flags[FLAG_C];
    assign ExecCount = r_exec_cnt;
    assign SkipCount = r_skip_cnt;

    // Flags only move when the instruction actually retires and passed its condition.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_flags    <= 4'b0000;
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else if (w_retire) begin
            if (w_cond_ex) begin
                if (FlagW[1]) r_flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
                if (FlagW[0]) r_flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
                r_exec_cnt <= r_exec_cnt + CNT_W'(1);
            end else begin
                r_skip_cnt <= r_skip_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed and random checks of cond_unit against a behavioural model.
module tb_cond_unit;

    logic        CLK = 1'b0;
    logic        Reset, Valid, Stall, Flush, PCS, RegW, MemW, NoWrite;
    logic [3:0]  Cond, ALUFlags;
    logic [1:0]  FlagW;
    logic        CondEx, PCSrc, RegWrite, MemWrite, CFlag;
    logic [3:0]  Flags;
    logic [31:0] ExecCount, SkipCount;
    logic        CondEx4, PCSrc4, RegWrite4, MemWrite4, CFlag4;
    logic [3:0]  Flags4, ExecCount4, SkipCount4;

    int n_chk = 0, n_pass = 0;
    logic [3:0]  m_flags;
    int unsigned m_exec, m_skip;

    always #5 CLK = ~CLK;

    cond_unit dut (
        .CLK(CLK), .Reset(Reset), .Valid(Valid), .Stall(Stall), .Flush(Flush),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .CondEx(CondEx), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags), .CFlag(CFlag),
        .ExecCount(ExecCount), .SkipCount(SkipCount)
    );

    cond_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .Reset(Reset), .Valid(Valid), .Stall(Stall), .Flush(Flush),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .CondEx(CondEx4), .PCSrc(PCSrc4),
        .RegWrite(RegWrite4), .MemWrite(MemWrite4), .Flags(Flags4), .CFlag(CFlag4),
        .ExecCount(ExecCount4), .SkipCount(SkipCount4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Conditions come in complementary pairs: the upper three bits pick a
    // predicate, the low bit inverts it; the 111x pair is always true.
    function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, p;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: p = z;
            3'd1: p = cy;
            3'd2: p = n;
            3'd3: p = v;
            3'd4: p = cy && !z;
            3'd5: p = (n == v);
            3'd6: p = !z && (n == v);
            default: return 1'b1;
        endcase
        return p ^ c[0];
    endfunction

    task automatic settle();
        logic ce, live;
        #1;
        ce   = m_cond(Cond, m_flags);
        live = Valid && !Flush;
        check("condex", CondEx, ce);
        check("pcsrc", PCSrc, PCS && ce && live);
        check("regwrite", RegWrite, RegW && !NoWrite && ce && live);
        check("memwrite", MemWrite, MemW && ce && live);
        check("flags", Flags, m_flags);
        check("cflag", CFlag, m_flags[1]);
        check("exec", ExecCount, m_exec);
        check("skip", SkipCount, m_skip);
        check("exec4", ExecCount4, m_exec % 16);
        check("skip4", SkipCount4, m_skip % 16);
        check("condex4", CondEx4, ce);
    endtask

    task automatic tick();
        logic ce;
        @(posedge CLK);
        ce = m_cond(Cond, m_flags);
        if (Reset) begin
            m_flags = 4'b0000; m_exec = 0; m_skip = 0;
        end else if (Valid && !Stall && !Flush) begin
            if (ce) begin
                if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
                if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
                m_exec++;
            end else m_skip++;
        end
        @(negedge CLK);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        {Reset, Valid, Stall, Flush, PCS, RegW, MemW, NoWrite} = '0;
        Cond = 4'd0; ALUFlags = 4'd0; FlagW = 2'd0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        idle();
        Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
        step();
    endtask

    initial begin
        idle();
        Reset = 1;
        m_flags = 'x; m_exec = 0; m_skip = 0;
        tick();
        idle();
        Valid = 1; RegW = 1; Cond = 4'b0000;
        settle();
        check("eq_condex", CondEx, 1'b0);
        check("eq_regwrite", RegWrite, 1'b0);
        tick();
        Cond = 4'b0001;
        settle();
        check("ne_regwrite", RegWrite, 1'b1);
        tick();
        idle();
        settle();
        check("first_skip", SkipCount, 32'd1);
        check("first_exec", ExecCount, 32'd1);
        Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110; NoWrite = 1; RegW = 1;
        settle();
        check("cmp_regwrite", RegWrite, 1'b0);
        tick();
        idle();
        Valid = 1; Cond = 4'b1000;
        settle();
        check("cmp_flags", Flags, 4'b0110);
        check("cmp_cflag", CFlag, 1'b1);
        check("hi_condex", CondEx, 1'b0);
        tick();
        set_flags(4'b1001);
        FlagW = 2'b10; ALUFlags = 4'b0110;
        step();
        FlagW = 2'b01; ALUFlags = 4'b1000;
        settle();
        check("partial_nz", Flags, 4'b0101);
        tick();
        idle();
        settle();
        check("partial_cv", Flags, 4'b0100);
        set_flags(4'b0000);
        Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111;
        step();
        idle();
        settle();
        check("failed_write", Flags, 4'b0000);
        idle();
        Valid = 1; Stall = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1000;
        RegW = 1; PCS = 1; MemW = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_regwrite", RegWrite, 1'b1);
            tick();
        end
        Flush = 1;
        settle();
        check("flush_outs", {PCSrc, RegWrite, MemWrite}, 3'b000);
        tick();
        idle();
        settle();
        check("stall_flags", Flags, 4'b0000);
        set_flags(4'b1111);
        Valid = 1; Reset = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
        step();
        Reset = 0; Cond = 4'b0001;
        settle();
        check("rst_mid_flags", Flags, 4'b0000);
        check("rst_mid_ne", CondEx, 1'b1);
        tick();
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            idle();
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c);
                step();
            end
        end
        idle();
        Reset = 1;
        step();
        idle();
        Valid = 1; Cond = 4'b1110;
        for (int i = 0; i < 17; i++) step();
        idle();
        settle();
        check("wrap4", ExecCount4, 4'd1);
        for (int i = 0; i < 600; i++) begin
            Reset    = ($urandom_range(0, 49) == 0);
            Valid    = ($urandom_range(0, 3) != 0);
            Stall    = ($urandom_range(0, 4) == 0);
            Flush    = ($urandom_range(0, 6) == 0);
            Cond     = 4'($urandom);
            ALUFlags = 4'($urandom);
            FlagW    = 2'($urandom);
            {PCS, RegW, MemW, NoWrite} = 4'($urandom);
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
